qnigma_tcp_tx_sched: RTL
========================

# qnigma_tcp_tx_sched

Transmit scheduler that shares the single TCP segment transmitter among the connection's event sources: control (FIN/RST), pure ACK, keep-alive probe and data/retransmit. It arbitrates level-held send requests, sequences the transmitter through a start/done handshake, and returns a one-cycle `sent` pulse to the winning requester. It sits between the per-connection TCP sub-controllers and the TCP TX engine.

## Interface
- `N_REQ`, 4: number of requesters. Index 0 has the highest fixed priority; index `N_REQ-1` has the lowest.
- `TX_TIMEOUT`, 4096: clock cycles allowed from `tx_start` to `tx_done` before the transfer is abandoned.
- `AGE_MAX`, 8: lost arbitrations before a pending requester is promoted. Only used with aging enabled.

Ports (clock and reset first):
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `flush`  in  1  connection torn down. Aborts any transfer and clears the scheduler.
- `req`  in  N_REQ  level send requests. Each is held until its `sent` pulse or until `flush`.
- `sent`  out  N_REQ  one-hot, one-cycle completion pulse to the granted requester.
- `tx_start`  out  1  one-cycle start pulse to the TX engine.
- `tx_sel`  out  $clog2(N_REQ)  index of the granted requester. Stable from `tx_start` until the scheduler returns to IDLE.
- `tx_done`  in  1  TX engine finished the segment (single-cycle pulse).
- `busy`  out  1  high in any state other than IDLE.
- `tx_err`  out  1  one-cycle pulse when a transfer times out.

## Operation
- States and transitions:
  - IDLE → ARB when `req` != 0.
  - ARB → START.
  - START → WAIT.
  - WAIT → DONE on `tx_done`.
  - WAIT → IDLE on timeout.
  - DONE → IDLE.
- ARB: latches the winner into `tx_sel`. The winner is the lowest set index of `req`, subject to aging promotion (see Configuration).
- START: `tx_start`=1 for one cycle. Clears the watchdog counter.
- WAIT: the watchdog counter increments every cycle and saturates.
  - `tx_done` moves to DONE.
  - Watchdog count == `TX_TIMEOUT-1` with no `tx_done`: `tx_err` pulses and the state returns to IDLE. No `sent` is issued and the requester stays pending.
- DONE: `sent[tx_sel]`=1 for one cycle. This gives the requester a cycle to drop `req` before the next arbitration.
- A requester that deasserts `req` during START or WAIT is still completed normally: the segment is already committed.
- `tx_done` outside WAIT is ignored.
- `flush` has priority over everything, in any state:
  - next state is IDLE;
  - `sent`, `tx_start` and `tx_err` are forced to 0 in that cycle;
  - age counters are cleared.
- `flush` coincident with `tx_done` yields no `sent` pulse.
- `flush` held high keeps the block in IDLE regardless of `req`.
- Watchdog counter width is `$clog2(TX_TIMEOUT+1)`.

## Timing
- Reset values:
  - `sent`=0, `tx_start`=0, `tx_err`=0, `busy`=0;
  - `tx_sel`=0, state IDLE;
  - watchdog and age counters 0.
- `req` rising in cycle t (block in IDLE) gives:
  - ARB at t+1;
  - `tx_start` at t+2;
  - `tx_done` at t+k (k≥3) gives `sent` at t+k+1 and IDLE at t+k+2.
- Minimum spacing between two `tx_start` pulses is 4 cycles after `tx_done`.
- All outputs are registered; there is no combinational path from input to output.
- `busy` = (state != IDLE), registered.

## Configuration
- Macro: `QNIGMA_TCP_SCHED_AGING_EN`.
- Defined:
  - Each requester has an age counter of width `$clog2(AGE_MAX+1)`.
  - In ARB, every pending non-winner's counter increments and saturates at `AGE_MAX`.
  - The winner's counter clears.
  - A requester whose counter equals `AGE_MAX` wins ahead of fixed priority; among several aged requesters, the lowest index wins.
- Not defined:
  - Pure fixed priority.
  - Age logic and the `AGE_MAX` parameter usage are compiled out.

## Test plan
- `req`=4'b0100 and `tx_done` 5 cycles after `tx_start` → `tx_sel`=2, `tx_start` at t+2, `sent`=4'b0100 for one cycle, `busy` low 2 cycles after `tx_done`.
- `req`=4'b1011 held, every `sent` bit dropping its `req` → grant order 0, 1, 3; no double `sent`.
- No `tx_done` after `tx_start` with `TX_TIMEOUT`=16 → `tx_err` pulses 16 cycles after `tx_start`, no `sent`, re-arbitration regrants the same index.
- `flush` in the same cycle as `tx_done` → no `sent`, IDLE next cycle. `flush` in WAIT → `busy`=0 next cycle.
- Aging enabled, `AGE_MAX`=2, `req[0]` re-raised immediately after each `sent` with `req[3]` held → index 3 is granted on the 3rd arbitration. Aging disabled → index 3 is never granted while `req[0]` stays busy.
- Reset asserted mid-WAIT → all outputs 0 and state IDLE on the next cycle; a late `tx_done` is ignored.

Source files
------------

// File: rtl/qnigma_tcp_tx_sched.sv
// Transmit scheduler: arbitrates TCP send requests onto one TX engine with a start/done handshake.
// Optional age-based promotion is compiled in with `define QNIGMA_TCP_SCHED_AGING_EN.
module qnigma_tcp_tx_sched #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned TX_TIMEOUT = 4096,
  parameter int unsigned AGE_MAX    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         sent,
  output logic                     tx_start,
  output logic [$clog2(N_REQ)-1:0] tx_sel,
  input  logic                     tx_done,
  output logic                     busy,
  output logic                     tx_err
);

  localparam int unsigned SEL_W = $clog2(N_REQ);
  localparam int unsigned WD_W  = $clog2(TX_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TX_TIMEOUT - 1);
  localparam logic [WD_W-1:0] WD_SAT  = WD_W'(TX_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_START,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WD_W-1:0]  wd;
  logic [SEL_W-1:0] winner;
  logic             timeout;

  function automatic logic [SEL_W-1:0] lowest(input logic [N_REQ-1:0] v);
    logic found;
    lowest = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (v[i] && !found) begin
        lowest = SEL_W'(i);
        found  = 1'b1;
      end
    end
  endfunction

`ifdef QNIGMA_TCP_SCHED_AGING_EN
  localparam int unsigned AGE_W = $clog2(AGE_MAX + 1);
  localparam logic [AGE_W-1:0] AGE_TOP = AGE_W'(AGE_MAX);

  logic [AGE_W-1:0] age [N_REQ];
  logic [N_REQ-1:0] aged;

  always_comb begin
    aged = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      aged[i] = req[i] && (age[i] == AGE_TOP);
    end
  end

  // A starved requester overrides fixed priority; ties among aged ones still go lowest-first.
  assign winner = (aged != '0) ? lowest(aged) : lowest(req);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        age[i] <= '0;
      end
    end else if (state == S_ARB) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (SEL_W'(i) == winner) begin
          age[i] <= '0;
        end else if (req[i] && (age[i] != AGE_TOP)) begin
          age[i] <= age[i] + AGE_W'(1);
        end
      end
    end
  end
`else
  assign winner = lowest(req);

  // AGE_MAX only matters when aging is compiled in.
  if (AGE_MAX == 0) begin : g_age_unused
  end
`endif

  assign timeout = (wd == WD_LAST);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (req != '0) state_nx = S_ARB;
      S_ARB:   state_nx = S_START;
      S_START: state_nx = S_WAIT;
      S_WAIT: begin
        if (tx_done) begin
          state_nx = S_DONE;
        end else if (timeout) begin
          state_nx = S_IDLE;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (flush) state_nx = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  // The watchdog starts counting in the tx_start cycle, so the abort lands TX_TIMEOUT cycles later.
  always_ff @(posedge clk) begin
    if (rst) begin
      sent     <= '0;
      tx_start <= 1'b0;
      tx_err   <= 1'b0;
      busy     <= 1'b0;
      tx_sel   <= '0;
      wd       <= '0;
    end else begin
      busy     <= (state_nx != S_IDLE);
      tx_start <= (state_nx == S_START);
      tx_err   <= !flush && (state == S_WAIT) && !tx_done && timeout;
      sent     <= '0;
      if (state_nx == S_DONE) sent[tx_sel] <= 1'b1;
      if ((state == S_ARB) && !flush) tx_sel <= winner;
      if (flush || (state == S_ARB)) begin
        wd <= '0;
      end else if (((state == S_START) || (state == S_WAIT)) && (wd != WD_SAT)) begin
        wd <= wd + WD_W'(1);
      end
    end
  end

endmodule
